// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the I2C bus arbiter: FSM state encoding,
// default sizing constants and the per-requester command record.
package i2c_arb_pkg;

    localparam int DEF_MAX_BYTES      = 6;
    localparam int DEF_TIMEOUT_CYCLES = 20000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic [6:0]                   dev_addr;
        logic [7:0]                   addr;
        logic [DEF_MAX_BYTES-1:0]     num_bytes;
        logic                         write;
        logic [DEF_MAX_BYTES*8-1:0]   wdata;
    } cmd_t;

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from last_winner+1,
// wrapping from NUM_REQ-1 back to 0, and returns the first pending requester.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = last_winner;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IDX_W'(NUM_REQ - 1)) begin
                idx = '0;
            end else begin
                idx = idx + 1'b1;
            end
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end else begin
                winner = winner;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C low-level driver between NUM_REQ requesters (round-robin).
// Optional watchdog in BUSY enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int MAX_BYTES      = DEF_MAX_BYTES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                           i2c_clock,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*7-1:0]           req_dev_addr,
    input  logic [NUM_REQ*8-1:0]           req_addr,
    input  logic [NUM_REQ*MAX_BYTES-1:0]   req_num_bytes,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             ack,
    output logic [MAX_BYTES*8-1:0]         rdata,
    output logic                           err,
    output logic                           drv_disable,
    output logic [6:0]                     drv_dev_addr,
    output logic [7:0]                     drv_addr,
    output logic [MAX_BYTES-1:0]           drv_num_bytes,
    output logic                           drv_write,
    output logic [MAX_BYTES*8-1:0]         drv_data_in,
    output logic                           drv_start,
    input  logic [MAX_BYTES*8-1:0]         drv_data_out,
    input  logic                           drv_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [MAX_BYTES*8-1:0] rdata_q, rdata_d;
    logic                   drv_disable_q, drv_disable_d;
    logic [6:0]             drv_dev_addr_q, drv_dev_addr_d;
    logic [7:0]             drv_addr_q, drv_addr_d;
    logic [MAX_BYTES-1:0]   drv_num_bytes_q, drv_num_bytes_d;
    logic                   drv_write_q, drv_write_d;
    logic [MAX_BYTES*8-1:0] drv_data_in_q, drv_data_in_d;
    logic                   drv_start_q, drv_start_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       last_winner_q, last_winner_d;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [MAX_BYTES-1:0]   nb_sel;
`ifdef I2C_ARB_TIMEOUT_EN
    logic                   err_q, err_d;
    logic [15:0]            cnt_q, cnt_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req         (req),
        .last_winner (last_winner_q),
        .winner      (pick_idx),
        .valid       (pick_valid)
    );

    // Next-state and registered-output computation for the arbiter FSM
    always_comb begin
        state_d         = state_q;
        gnt_d           = gnt_q;
        ack_d           = '0;
        rdata_d         = rdata_q;
        drv_disable_d   = drv_disable_q;
        drv_dev_addr_d  = drv_dev_addr_q;
        drv_addr_d      = drv_addr_q;
        drv_num_bytes_d = drv_num_bytes_q;
        drv_write_d     = drv_write_q;
        drv_data_in_d   = drv_data_in_q;
        drv_start_d     = 1'b0;
        owner_d         = owner_q;
        last_winner_d   = last_winner_q;
        nb_sel          = req_num_bytes[int'(pick_idx)*MAX_BYTES +: MAX_BYTES];
`ifdef I2C_ARB_TIMEOUT_EN
        err_d           = err_q;
        cnt_d           = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d           = NUM_REQ'(1) << pick_idx;
                    owner_d         = pick_idx;
                    drv_disable_d   = 1'b0;
                    drv_dev_addr_d  = req_dev_addr[int'(pick_idx)*7 +: 7];
                    drv_addr_d      = req_addr[int'(pick_idx)*8 +: 8];
                    drv_write_d     = req_write[pick_idx];
                    drv_data_in_d   = req_wdata[int'(pick_idx)*MAX_BYTES*8 +: MAX_BYTES*8];
                    // Zero passes through: it denotes an address-only write.
                    if (nb_sel > MAX_BYTES'(MAX_BYTES)) begin
                        drv_num_bytes_d = MAX_BYTES'(MAX_BYTES);
                    end else begin
                        drv_num_bytes_d = nb_sel;
                    end
                    state_d         = ST_START;
                end else begin
                    state_d         = ST_IDLE;
                end
            end
            ST_START: begin
                drv_start_d = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_d       = 16'd0;
`endif
                state_d     = ST_BUSY;
            end
            ST_BUSY: begin
                // ack is raised here so it appears one cycle after drv_done.
                if (drv_done) begin
                    if (!drv_write_q) begin
                        rdata_d = drv_data_out;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    ack_d   = gnt_q;
                    state_d = ST_RESP;
                end else begin
`ifdef I2C_ARB_TIMEOUT_EN
                    if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        ack_d   = gnt_q;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                    end
`else
                    state_d = ST_BUSY;
`endif
                end
            end
            ST_RESP: begin
                gnt_d         = '0;
                drv_disable_d = 1'b1;
                last_winner_d = owner_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge i2c_clock or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            gnt_q           <= '0;
            ack_q           <= '0;
            rdata_q         <= '0;
            drv_disable_q   <= 1'b1;
            drv_dev_addr_q  <= 7'd0;
            drv_addr_q      <= 8'd0;
            drv_num_bytes_q <= '0;
            drv_write_q     <= 1'b0;
            drv_data_in_q   <= '0;
            drv_start_q     <= 1'b0;
            owner_q         <= '0;
            last_winner_q   <= IDX_W'(NUM_REQ - 1);
`ifdef I2C_ARB_TIMEOUT_EN
            err_q           <= 1'b0;
            cnt_q           <= 16'd0;
`endif
        end else begin
            state_q         <= state_d;
            gnt_q           <= gnt_d;
            ack_q           <= ack_d;
            rdata_q         <= rdata_d;
            drv_disable_q   <= drv_disable_d;
            drv_dev_addr_q  <= drv_dev_addr_d;
            drv_addr_q      <= drv_addr_d;
            drv_num_bytes_q <= drv_num_bytes_d;
            drv_write_q     <= drv_write_d;
            drv_data_in_q   <= drv_data_in_d;
            drv_start_q     <= drv_start_d;
            owner_q         <= owner_d;
            last_winner_q   <= last_winner_d;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q           <= err_d;
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign gnt           = gnt_q;
    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign drv_disable   = drv_disable_q;
    assign drv_dev_addr  = drv_dev_addr_q;
    assign drv_addr      = drv_addr_q;
    assign drv_num_bytes = drv_num_bytes_q;
    assign drv_write     = drv_write_q;
    assign drv_data_in   = drv_data_in_q;
    assign drv_start     = drv_start_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: reset, read, contention, write, clamp,
// mid-transaction reset and BUSY watchdog behaviour (with/without the macro).
module tb_i2c_bus_arbiter;
    import i2c_arb_pkg::*;

    localparam int NR = 2;
    localparam int MB = DEF_MAX_BYTES;
`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = DEF_TIMEOUT_CYCLES;
`endif

    logic              i2c_clock = 1'b0;
    logic              rst;
    logic [NR-1:0]     req, req_write, gnt, ack;
    logic [NR*7-1:0]   req_dev_addr;
    logic [NR*8-1:0]   req_addr;
    logic [NR*MB-1:0]  req_num_bytes;
    logic [NR*MB*8-1:0] req_wdata;
    logic [MB*8-1:0]   rdata, drv_data_in, drv_data_out;
    logic              err, drv_disable, drv_write, drv_start, drv_done;
    logic [6:0]        drv_dev_addr;
    logic [7:0]        drv_addr;
    logic [MB-1:0]     drv_num_bytes;

    int n_checks = 0;
    int n_pass   = 0;

    i2c_bus_arbiter #(
        .NUM_REQ(NR), .MAX_BYTES(MB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i2c_clock(i2c_clock), .rst(rst),
        .req(req), .req_dev_addr(req_dev_addr), .req_addr(req_addr),
        .req_num_bytes(req_num_bytes), .req_write(req_write), .req_wdata(req_wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .err(err),
        .drv_disable(drv_disable), .drv_dev_addr(drv_dev_addr), .drv_addr(drv_addr),
        .drv_num_bytes(drv_num_bytes), .drv_write(drv_write), .drv_data_in(drv_data_in),
        .drv_start(drv_start), .drv_data_out(drv_data_out), .drv_done(drv_done)
    );

    always #5 i2c_clock = ~i2c_clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge i2c_clock);
    endtask

    task automatic set_cmd(input int r, input cmd_t c);
        req_dev_addr[r*7 +: 7]        = c.dev_addr;
        req_addr[r*8 +: 8]            = c.addr;
        req_num_bytes[r*MB +: MB]     = c.num_bytes;
        req_write[r]                  = c.write;
        req_wdata[r*MB*8 +: MB*8]     = c.wdata;
    endtask

    // Waits (bounded) for any grant; n is the number of cycles it took.
    task automatic wait_gnt(output logic [NR-1:0] g, output int n);
        g = '0;
        n = 0;
        for (int i = 0; i < 20 && g == '0; i++) begin
            tick();
            g = gnt;
            n = i + 1;
        end
        check("gnt_seen", 64'(g != '0), 64'd1);
    endtask

    // Called in the START cycle; returns ack as seen one cycle after drv_done.
    task automatic finish_txn(input logic [MB*8-1:0] data, output logic [NR-1:0] a);
        tick();
        check("drv_start_hi", 64'(drv_start), 64'd1);
        tick();
        check("drv_start_lo", 64'(drv_start), 64'd0);
        drv_data_out = data;
        drv_done     = 1'b1;
        tick();
        drv_done     = 1'b0;
        a            = ack;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [NR-1:0]   g, a;
        int              n, first;
        logic [MB*8-1:0] last_rd;

        rst = 1'b1; req = '0; req_write = '0; req_dev_addr = '0; req_addr = '0;
        req_num_bytes = '0; req_wdata = '0; drv_data_out = '0; drv_done = 1'b0;
        tick(); tick();
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_start", 64'(drv_start), 64'd0);
        check("rst_disable", 64'(drv_disable), 64'd1);
        check("rst_dev_addr", 64'(drv_dev_addr), 64'd0);
        check("rst_nbytes", 64'(drv_num_bytes), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // Single read from requester 0
        set_cmd(0, cmd_t'{7'h52, 8'h00, 6'd6, 1'b0, 48'h0});
        req = 2'b01;
        wait_gnt(g, n);
        check("rd_gnt", 64'(g), 64'h1);
        check("rd_gnt_latency", 64'(n), 64'd1);
        check("rd_disable", 64'(drv_disable), 64'd0);
        check("rd_dev_addr", 64'(drv_dev_addr), 64'h52);
        check("rd_nbytes", 64'(drv_num_bytes), 64'd6);
        check("rd_start_early", 64'(drv_start), 64'd0);
        finish_txn(48'h665544332211, a);
        check("rd_ack", 64'(a), 64'h1);
        check("rd_rdata", 64'(rdata), 64'h665544332211);
        check("rd_err", 64'(err), 64'd0);
        req = 2'b00;
        tick();
        check("rd_ack_pulse", 64'(ack), 64'd0);
        check("rd_gnt_clr", 64'(gnt), 64'd0);
        check("rd_disable_idle", 64'(drv_disable), 64'd1);

        // Contention after reset; requester 0 re-requests immediately
        do_reset();
        set_cmd(1, cmd_t'{7'h33, 8'h10, 6'd2, 1'b0, 48'h0});
        req = 2'b11;
        wait_gnt(g, n);
        check("cont_first", 64'(g), 64'h1);
        finish_txn(48'h0000000000a1, a);
        check("cont_ack0", 64'(a), 64'h1);
        wait_gnt(g, n);
        check("cont_second", 64'(g), 64'h2);
        check("cont_spacing", 64'(n), 64'd2);
        check("cont_dev1", 64'(drv_dev_addr), 64'h33);
        finish_txn(48'h00000000b2c3, a);
        check("cont_ack1", 64'(a), 64'h2);
        req[1] = 1'b0;
        wait_gnt(g, n);
        check("cont_third", 64'(g), 64'h1);
        finish_txn(48'h0000000000d4, a);
        check("hold_ack0", 64'(a), 64'h1);
        req[0] = 1'b0;
        last_rd = 48'h0000000000d4;
        check("hold_rdata", 64'(rdata), 64'(last_rd));

        // Single-byte write from requester 1
        set_cmd(1, cmd_t'{7'h52, 8'hF0, 6'd1, 1'b1, 48'h55});
        req = 2'b10;
        wait_gnt(g, n);
        check("wr_gnt", 64'(g), 64'h2);
        check("wr_write", 64'(drv_write), 64'd1);
        check("wr_data0", 64'(drv_data_in[7:0]), 64'h55);
        check("wr_addr", 64'(drv_addr), 64'hF0);
        finish_txn(48'hbadbadbadbad, a);
        check("wr_ack", 64'(a), 64'h2);
        check("wr_rdata_keep", 64'(rdata), 64'(last_rd));
        req = 2'b00;

        // Clamp, plus requester dropping req and changing fields mid-transaction
        set_cmd(0, cmd_t'{7'h52, 8'h01, 6'd9, 1'b0, 48'h0});
        req = 2'b01;
        wait_gnt(g, n);
        check("clamp_nbytes", 64'(drv_num_bytes), 64'd6);
        req = 2'b00;
        req_dev_addr[6:0] = 7'h11;
        finish_txn(48'h0a0b0c0d0e0f, a);
        check("drop_ack", 64'(a), 64'h1);
        check("drop_dev_stable", 64'(drv_dev_addr), 64'h52);
        last_rd = 48'h0a0b0c0d0e0f;

        // Zero byte count passes through
        set_cmd(0, cmd_t'{7'h52, 8'h02, 6'd0, 1'b1, 48'h0});
        req = 2'b01;
        wait_gnt(g, n);
        check("zero_nbytes", 64'(drv_num_bytes), 64'd0);
        finish_txn(48'h0, a);
        check("zero_ack", 64'(a), 64'h1);
        req = 2'b00;

        // Reset asserted in BUSY abandons the transaction
        set_cmd(1, cmd_t'{7'h52, 8'h03, 6'd1, 1'b0, 48'h0});
        req = 2'b10;
        wait_gnt(g, n);
        tick();
        req = 2'b00;
        rst = 1'b1;
        #1;
        check("mrst_disable", 64'(drv_disable), 64'd1);
        check("mrst_gnt", 64'(gnt), 64'd0);
        check("mrst_rdata", 64'(rdata), 64'd0);
        tick();
        rst = 1'b0;
        drv_done = 1'b1;
        tick();
        drv_done = 1'b0;
        first = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack != '0) first++;
        end
        check("mrst_no_ack", 64'(first), 64'd0);
        req = 2'b11;
        wait_gnt(g, n);
        check("mrst_idle_gnt", 64'(g), 64'h1);
        check("mrst_idle_latency", 64'(n), 64'd1);
        finish_txn(48'h000000000077, a);
        check("mrst_ack", 64'(a), 64'h1);
        req = 2'b00;
        last_rd = 48'h000000000077;
        tick();

        // BUSY without drv_done
        set_cmd(0, cmd_t'{7'h52, 8'h04, 6'd2, 1'b0, 48'h0});
        req = 2'b01;
        wait_gnt(g, n);
        tick();
        first = 0;
        for (int k = 2; k <= 1000 && first == 0; k++) begin
            tick();
            if (ack != '0) first = k;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        check("to_cycle", 64'(first), 64'd51);
        check("to_err", 64'(err), 64'd1);
        check("to_rdata_keep", 64'(rdata), 64'(last_rd));
        req = 2'b00;
`else
        check("noto_ack", 64'(first), 64'd0);
        check("noto_gnt_held", 64'(gnt), 64'h1);
        check("noto_err", 64'(err), 64'd0);
        drv_data_out = 48'h00000000abcd;
        drv_done = 1'b1;
        tick();
        drv_done = 1'b0;
        check("noto_late_ack", 64'(ack), 64'h1);
        check("noto_rdata", 64'(rdata), 64'h00000000abcd);
        req = 2'b00;
`endif
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters sharing one I2C low-level driver.
REQ-002 The block SHALL have parameter MAX_BYTES, default 6, giving the maximum transfer length in bytes.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 20000, giving the watchdog limit in i2c_clock cycles.
REQ-004 The block SHALL have these clock and reset ports:
- i2c_clock  in  1  clock; reset rst, asynchronous, active-high; clock i2c_clock.
- rst  in  1  asynchronous active-high reset.
REQ-005 The block SHALL have these requester-side ports:
- req  in  NUM_REQ  per-requester transaction request, held high until ack.
- req_dev_addr  in  NUM_REQ*7  per-requester 7-bit device address.
- req_addr  in  NUM_REQ*8  per-requester register address.
- req_num_bytes  in  NUM_REQ*MAX_BYTES  per-requester byte count.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_wdata  in  NUM_REQ*MAX_BYTES*8  per-requester write bytes.
- gnt  out  NUM_REQ  one-hot owner indication.
- ack  out  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  out  MAX_BYTES*8  read bytes from the last completed transaction.
- err  out  1  timeout flag for the acked transaction.
REQ-006 The block SHALL have these driver-side ports:
- drv_disable  out  1  disables the driver while the block is idle.
- drv_dev_addr  out  7  device address to the driver.
- drv_addr  out  8  register address to the driver.
- drv_num_bytes  out  MAX_BYTES  byte count to the driver.
- drv_write  out  1  write enable to the driver.
- drv_data_in  out  MAX_BYTES*8  write bytes to the driver.
- drv_start  out  1  one-cycle start pulse to the driver.
- drv_data_out  in  MAX_BYTES*8  read bytes from the driver.
- drv_done  in  1  transaction-complete pulse from the driver.

Function
REQ-007 The block SHALL implement the states IDLE, START, BUSY and RESP, with all outputs registered.
REQ-008 In IDLE, when any req bit is high, the block SHALL pick a winner round-robin, searching upward from last_winner+1 with wrap at NUM_REQ-1 to 0.
REQ-009 In the same IDLE cycle, the block SHALL latch the winner's command fields onto the drv_* outputs, set gnt[winner], clear drv_disable, and move to START.
REQ-010 In START, the block SHALL assert drv_start for exactly one cycle and then move to BUSY; drv_done SHALL be ignored in START.
REQ-011 In BUSY, on drv_done the block SHALL capture drv_data_out into rdata (reads only; rdata SHALL stay unchanged on writes), clear err, and move to RESP.
REQ-012 In RESP, the block SHALL pulse ack[winner] for one cycle, clear gnt, set drv_disable, record last_winner, and return to IDLE.
REQ-013 Grant-to-start latency SHALL be 1 cycle; drv_done-to-ack latency SHALL be 1 cycle; the minimum spacing between back-to-back grants SHALL be 1 IDLE cycle.
REQ-014 drv_* command outputs SHALL remain stable from START through RESP; a requester dropping req mid-transaction SHALL NOT abort it, and ack SHALL still pulse.
REQ-015 A req_num_bytes value greater than MAX_BYTES SHALL be clamped to MAX_BYTES; a value of 0 SHALL be passed through unchanged (address-only write).
REQ-016 A single requester that holds req continuously SHALL be re-granted each round when no other requester is pending.

Reset
REQ-017 Asserting rst SHALL force IDLE, gnt=0, ack=0, drv_start=0, drv_disable=1, and all other drv_* outputs to 0.
REQ-018 Asserting rst SHALL also force rdata=0, err=0, and last_winner=NUM_REQ-1, so that requester 0 wins first.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction with no ack.

Configuration
REQ-020 With macro I2C_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL run in BUSY; on reaching TIMEOUT_CYCLES without drv_done, the block SHALL go to RESP with err=1 and rdata unchanged.
REQ-021 Without I2C_ARB_TIMEOUT_EN, err SHALL be tied to 0 and BUSY SHALL wait indefinitely for drv_done.

Structure
REQ-022 Package i2c_arb_pkg SHALL hold the state enum, the default MAX_BYTES and TIMEOUT_CYCLES constants, and a command struct (dev_addr, addr, num_bytes, write, wdata).
REQ-023 The round-robin winner selection SHALL be a separate combinational sub-module rr_pick (inputs: req, last_winner; outputs: winner index, valid).

Verification
REQ-024 Single read: req[0] with dev 0x52, addr 0x00, 6 bytes, write=0 -> gnt[0] next cycle, drv_start one cycle later; driver returns 0x11..0x66 -> rdata matches, ack[0] one cycle after drv_done.
REQ-025 Contention: req=2'b11 asserted together after reset -> requester 0 served first, then requester 1; repeating the request gives order 1 then 0.
REQ-026 Write: req[1] with dev 0x52, addr 0xF0, 1 byte, wdata 0x55 -> drv_write=1, drv_data_in[7:0]=0x55, rdata unchanged after ack.
REQ-027 Reset mid-operation: rst in BUSY -> drv_disable=1, gnt=0, no ack, state IDLE.
REQ-028 Timeout with I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50: no drv_done -> ack with err=1 at cycle 51 of BUSY; without the macro, no ack after 1000 cycles.
REQ-029 Clamp: req_num_bytes=9 with MAX_BYTES=6 -> drv_num_bytes=6.
